rom_load_ctrl: RTL

Sequences the HPS ROM download stream into the game core's ROM regions for the Green Beret / Rush'n Attack core. It decodes each download byte into one of four regions and emits a one-cycle, registered, region-local write. It also owns the core reset: the core stays in reset while a download is active, and afterwards until the image is verified complete plus a hold delay. It sits between the `hps_io` ioctl outputs and the game core's ROM write ports, and replaces the direct `ROMAD/ROMDT/ROMEN` connection.

---
 rtl/rom_load_pkg.sv | 47 ++++
 rtl/rom_region_decode.sv | 53 +++++
 rtl/rom_load_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rom_load_pkg.sv
// Shared definitions for the ROM download sequencer: region map, region
// and controller state enumerations, image size and a counter helper.
package rom_load_pkg;

    localparam int ADDR_W  = 25;
    localparam int LOCAL_W = 16;
    localparam int HOLD_W  = 16;

    // Region map in download byte address space (inclusive limits).
    localparam logic [24:0] CPU_BASE  = 25'h00000;
    localparam logic [24:0] CPU_LAST  = 25'h0BFFF;
    localparam logic [24:0] CHR_BASE  = 25'h0C000;
    localparam logic [24:0] CHR_LAST  = 25'h0FFFF;
    localparam logic [24:0] SPR_BASE  = 25'h10000;
    localparam logic [24:0] SPR_LAST  = 25'h1FFFF;
    localparam logic [24:0] PROM_BASE = 25'h20000;
    localparam logic [24:0] PROM_LAST = 25'h2021F;
    // Inside the PROM region: palette at local 0x000, sprite lookup at
    // 0x020, char lookup at 0x120. The core splits these itself.

    // Size of the complete Green Beret image.
    localparam logic [24:0] TOTAL_BYTES_DEF = 25'h20220;

    typedef enum logic [1:0] {
        RGN_CPU  = 2'd0,
        RGN_CHR  = 2'd1,
        RGN_SPR  = 2'd2,
        RGN_PROM = 2'd3
    } rgn_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } state_e;

    // Saturating increment for the byte counter: sticks at all-ones.
    function automatic logic [24:0] sat_inc(input logic [24:0] v);
        if (v == {25{1'b1}}) begin
            return v;
        end else begin
            return v + 25'd1;
        end
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// Combinational decode of a download byte address into its ROM region:
// region hit flag, one-hot region select and region-local byte address.
module rom_region_decode
    import rom_load_pkg::*;
(
    input  logic [24:0] dl_addr,
    output logic        rgn_valid,
    output logic [3:0]  rgn_one_hot,
    output logic [15:0] rgn_local
);

    rgn_idx_e    idx_s;
    logic [15:0] base_lo_s;

    // Pick the region and its base; every region base is 64K aligned except
    // the char ROM, so only the low 16 address bits take part in the offset.
    always_comb begin
        idx_s     = RGN_CPU;
        base_lo_s = CPU_BASE[15:0];
        rgn_valid = 1'b1;
        if (dl_addr <= CPU_LAST) begin
            idx_s     = RGN_CPU;
            base_lo_s = CPU_BASE[15:0];
        end else if (dl_addr <= CHR_LAST) begin
            idx_s     = RGN_CHR;
            base_lo_s = CHR_BASE[15:0];
        end else if (dl_addr <= SPR_LAST) begin
            idx_s     = RGN_SPR;
            base_lo_s = SPR_BASE[15:0];
        end else if (dl_addr <= PROM_LAST) begin
            idx_s     = RGN_PROM;
            base_lo_s = PROM_BASE[15:0];
        end else begin
            rgn_valid = 1'b0;
        end

        case (idx_s)
            RGN_CPU:  rgn_one_hot = 4'b0001;
            RGN_CHR:  rgn_one_hot = 4'b0010;
            RGN_SPR:  rgn_one_hot = 4'b0100;
            RGN_PROM: rgn_one_hot = 4'b1000;
            default:  rgn_one_hot = 4'b0000;
        endcase
        if (!rgn_valid) begin
            rgn_one_hot = 4'b0000;
        end else begin
            rgn_one_hot = rgn_one_hot;
        end

        rgn_local = dl_addr[15:0] - base_lo_s;
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the HPS ioctl download into the Green Beret ROM regions and
// holds the game core in reset until a complete image has been verified.
// Bytes are accepted by the region map; TOTAL_BYTES governs only the
// completeness check (for the shipped image both limits coincide).
module rom_load_ctrl
    import rom_load_pkg::*;
#(
    parameter int          HOLD_CYC    = 16,
    parameter logic [24:0] TOTAL_BYTES = TOTAL_BYTES_DEF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    output logic [3:0]  rgn_we,
    output logic [15:0] rgn_addr,
    output logic [7:0]  rgn_data,
    output logic        core_reset,
    output logic        rom_ready,
    output logic        err_oob,
    output logic        err_short
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [24:0]       byte_cnt_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic [HOLD_W-1:0] hold_nxt_s;
    logic              err_oob_r;
    logic              err_short_r;
    logic              short_nxt_s;
    logic [3:0]        rgn_we_r;
    logic [15:0]       rgn_addr_r;
    logic [7:0]        rgn_data_r;
    logic              core_reset_r;
    logic              rom_ready_r;

    logic              dec_valid_s;
    logic [3:0]        dec_one_hot_s;
    logic [15:0]       dec_local_s;

    logic              entering_s;
    logic              accept_s;
    logic              wr_ok_s;
    logic [24:0]       cnt_base_s;
    logic [24:0]       cnt_upd_s;
    logic              oob_upd_s;
    logic              load_ok_s;
    logic              run_out_s;

    rom_region_decode u_decode (
        .dl_addr     (dl_addr),
        .rgn_valid   (dec_valid_s),
        .rgn_one_hot (dec_one_hot_s),
        .rgn_local   (dec_local_s)
    );

    // Byte acceptance and the counter/error values including this cycle's
    // byte, so a last byte coincident with dl_active falling is counted
    // before the completeness check.
    always_comb begin
        entering_s = dl_active && (state_r != ST_LOAD);
        accept_s   = dl_wr && (dl_active || (state_r == ST_LOAD));
        wr_ok_s    = accept_s && dec_valid_s;
        if (entering_s) begin
            cnt_base_s = 25'd0;
            oob_upd_s  = 1'b0;
        end else begin
            cnt_base_s = byte_cnt_r;
            oob_upd_s  = err_oob_r;
        end
        if (wr_ok_s) begin
            cnt_upd_s = sat_inc(cnt_base_s);
        end else begin
            cnt_upd_s = cnt_base_s;
        end
        if (accept_s && !dec_valid_s) begin
            oob_upd_s = 1'b1;
        end else begin
            oob_upd_s = oob_upd_s;
        end
        load_ok_s = (cnt_upd_s == TOTAL_BYTES) && !oob_upd_s;
        run_out_s = (state_r == ST_RUN) && !dl_active;
    end

    // Next-state logic; any new download restarts loading from every state.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_cnt_r;
        short_nxt_s = err_short_r;
        case (state_r)
            ST_IDLE: begin
                if (dl_active) begin
                    state_nxt_s = ST_LOAD;
                    short_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (dl_active) begin
                    state_nxt_s = ST_LOAD;
                end else if (load_ok_s) begin
                    state_nxt_s = ST_HOLD;
                    hold_nxt_s  = HOLD_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                    short_nxt_s = (cnt_upd_s != TOTAL_BYTES);
                end
            end
            ST_HOLD: begin
                if (dl_active) begin
                    state_nxt_s = ST_LOAD;
                    short_nxt_s = 1'b0;
                end else if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    hold_nxt_s = hold_cnt_r - {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RUN: begin
                if (dl_active) begin
                    state_nxt_s = ST_LOAD;
                    short_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and sticky error flags.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            byte_cnt_r  <= 25'd0;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            err_oob_r   <= 1'b0;
            err_short_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            byte_cnt_r  <= cnt_upd_s;
            hold_cnt_r  <= hold_nxt_s;
            err_oob_r   <= oob_upd_s;
            err_short_r <= short_nxt_s;
        end
    end

    // Registered region write port and core reset / ready; a download
    // request forces the core back into reset on the edge that sees it.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rgn_we_r     <= 4'b0000;
            rgn_addr_r   <= 16'h0000;
            rgn_data_r   <= 8'h00;
            core_reset_r <= 1'b1;
            rom_ready_r  <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                rgn_we_r   <= dec_one_hot_s;
                rgn_addr_r <= dec_local_s;
                rgn_data_r <= dl_data;
            end else begin
                rgn_we_r   <= 4'b0000;
            end
            core_reset_r <= !run_out_s;
            rom_ready_r  <= run_out_s;
        end
    end

    assign rgn_we     = rgn_we_r;
    assign rgn_addr   = rgn_addr_r;
    assign rgn_data   = rgn_data_r;
    assign core_reset = core_reset_r;
    assign rom_ready  = rom_ready_r;
    assign err_oob    = err_oob_r;
    assign err_short  = err_short_r;

endmodule
